v_traffic_gen: RTL and testbench



---
 rtl/v_noc_pkg.sv | 58 +++++
 rtl/v_lfsr32.sv | 31 +++
 rtl/v_traffic_gen.sv | 138 +++++++++++++
 tb/tb_v_traffic_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_noc_pkg.sv
// Shared NoC types: node ids, port enum, test case bundle, traffic gen helpers.
// Ports: none (package).
package v_noc_pkg;

  localparam int NODE_X_W      = 4;
  localparam int NODE_Y_W      = 4;
  localparam int DEVICE_PORT_W = 2;
  localparam int TXN_ID_W      = 8;
  localparam int QOS_VALUE_W   = 4;
  localparam int FLIT_DATA_W   = 128;
  localparam int TIMEOUT_W     = 16;

  typedef struct packed {
    logic [DEVICE_PORT_W-1:0] device_port;
    logic [NODE_Y_W-1:0]      y;
    logic [NODE_X_W-1:0]      x;
  } node_id_t;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_S = 3'd3,
    PORT_W = 3'd4
  } io_port_t;

  typedef struct packed {
    node_id_t                 src_id;
    node_id_t                 tgt_id;
    io_port_t                 look_ahead_routing;
    logic [TXN_ID_W-1:0]      txn_id;
    logic [QOS_VALUE_W-1:0]   qos_value;
    logic [FLIT_DATA_W-1:0]   flit_data;
    logic [TIMEOUT_W-1:0]     timeout_threshold;
    logic [63:0]              mcycle_when_generated;
  } test_case_t;

  typedef enum logic [1:0] {
    TG_IDLE  = 2'd0,
    TG_RUN   = 2'd1,
    TG_DRAIN = 2'd2,
    TG_DONE  = 2'd3
  } traffic_gen_state_e;

  localparam logic [31:0] TRAFFIC_GEN_LFSR_TAPS = 32'h80200003;

  // XY dimension-order routing, first hop out of the source router.
  function automatic io_port_t xy_first_hop(node_id_t src, node_id_t tgt);
    io_port_t p;
    p = PORT_L;
    if (tgt.x > src.x)      p = PORT_E;
    else if (tgt.x < src.x) p = PORT_W;
    else if (tgt.y > src.y) p = PORT_N;
    else if (tgt.y < src.y) p = PORT_S;
    return p;
  endfunction

endpackage

// File: rtl/v_lfsr32.sv
// 32-bit right-shifting Galois LFSR with enable and loadable seed.
// Ports: clk, rst (sync, high), en_i, seed_i[31:0], state_o[31:0].
module v_lfsr32
  import v_noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]}
             ^ (lfsr_q[0] ? TRAFFIC_GEN_LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed_i;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/v_traffic_gen.sv
// Synthetic NoC traffic source feeding v_sender's test-generator port.
// Ports: clk, rst (sync, high), start_i, node_id_i, mcycle_i[63:0],
//   new_test_vld_o, new_test_o, new_test_rdy_i, issued_cnt_o[15:0], done_o.
// Option: TRAFFIC_GEN_SELF_TARGET_EN allows targets equal to own node.
module v_traffic_gen
  import v_noc_pkg::*;
#(
  parameter int          MESH_X            = 4,
  parameter int          MESH_Y            = 4,
  parameter int          TEST_NUM          = 64,
  parameter int          INJECT_RATE       = 128,
  parameter logic [31:0] LFSR_SEED         = 32'h1,
  parameter int          TIMEOUT_THRESHOLD = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  node_id_t    node_id_i,
  input  logic [63:0] mcycle_i,
  output logic        new_test_vld_o,
  output test_case_t  new_test_o,
  input  logic        new_test_rdy_i,
  output logic [15:0] issued_cnt_o,
  output logic        done_o
);

  // Mesh sizes are powers of two, so masking is a mod.
  localparam logic [NODE_X_W-1:0] XMASK = NODE_X_W'(MESH_X - 1);
  localparam logic [NODE_Y_W-1:0] YMASK = NODE_Y_W'(MESH_Y - 1);
  localparam logic [31:0]         TN    = 32'(TEST_NUM);

  traffic_gen_state_e state_q;
  logic [31:0]        gen_cnt_q;
  logic               vld_q;
  test_case_t         entry_q;
  logic [15:0]        issued_q;
  logic               done_q;

  logic [31:0] lfsr;
  logic        lfsr_en;
  node_id_t    tgt;
  logic        entry_ok;
  logic        hit;
  logic        hs;
  logic        load;
  test_case_t  entry_d;

  assign lfsr_en = (state_q == TG_RUN);

  v_lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr)
  );

  always_comb begin
    tgt      = '0;
    tgt.x    = lfsr[8 +: NODE_X_W] & XMASK;
    tgt.y    = lfsr[16 +: NODE_Y_W] & YMASK;
    entry_ok = 1'b1;
`ifndef TRAFFIC_GEN_SELF_TARGET_EN
    if (tgt.x == node_id_i.x && tgt.y == node_id_i.y) begin
      // A 1-wide mesh has no neighbour to shift onto.
      if (MESH_X == 1) entry_ok = 1'b0;
      else tgt.x = (node_id_i.x + NODE_X_W'(1)) & XMASK;
    end
`endif
  end

  // 9-bit compare so a rate of 256 always hits.
  assign hit  = ({1'b0, lfsr[7:0]} < 9'(INJECT_RATE)) && entry_ok;
  assign hs   = vld_q && new_test_rdy_i;
  assign load = (state_q == TG_RUN) && hit
             && (!vld_q || new_test_rdy_i) && (gen_cnt_q < TN);

  always_comb begin
    entry_d                       = '0;
    entry_d.src_id                = node_id_i;
    entry_d.tgt_id                = tgt;
    entry_d.look_ahead_routing    = xy_first_hop(node_id_i, tgt);
    entry_d.txn_id                = gen_cnt_q[TXN_ID_W-1:0];
    entry_d.qos_value             = lfsr[31 -: QOS_VALUE_W];
    entry_d.flit_data             = FLIT_DATA_W'({gen_cnt_q, lfsr});
    entry_d.timeout_threshold     = TIMEOUT_W'(TIMEOUT_THRESHOLD);
    entry_d.mcycle_when_generated = mcycle_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TG_IDLE;
      gen_cnt_q <= '0;
      vld_q     <= 1'b0;
      entry_q   <= '0;
      issued_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      if (hs && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (load) begin
        entry_q   <= entry_d;
        vld_q     <= 1'b1;
        gen_cnt_q <= gen_cnt_q + 32'd1;
      end else if (hs) begin
        vld_q <= 1'b0;
      end
      unique case (state_q)
        TG_IDLE: begin
          if (start_i) begin
            if (TEST_NUM == 0) begin
              state_q <= TG_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= TG_RUN;
            end
          end
        end
        TG_RUN: begin
          if (load && (gen_cnt_q + 32'd1 == TN)) state_q <= TG_DRAIN;
        end
        TG_DRAIN: begin
          if (hs) begin
            state_q <= TG_DONE;
            done_q  <= 1'b1;
          end
        end
        TG_DONE: done_q <= 1'b1;
        default: state_q <= TG_IDLE;
      endcase
    end
  end

  assign new_test_vld_o = vld_q;
  assign new_test_o     = entry_q;
  assign issued_cnt_o   = issued_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_v_traffic_gen.sv
// Directed bench for v_traffic_gen: routing table, stream, stall, reset, rates.
// Ports: none (top-level bench).
module tb_v_traffic_gen;
  import v_noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] mcycle = 64'd0;
  always @(posedge clk) mcycle <= mcycle + 64'd1;

  node_id_t node_a;
  node_id_t node_o;

  logic start_a = 0, rdy_a = 0, vld_a, done_a;
  logic start_z = 0, rdy_z = 0, vld_z, done_z;
  logic start_r = 0, rdy_r = 0, vld_r, done_r;
  logic start_n = 0, rdy_n = 0, vld_n, done_n;
  test_case_t ent_a, ent_z, ent_r, ent_n;
  logic [15:0] iss_a, iss_z, iss_r, iss_n;

  v_traffic_gen #(.MESH_X(4), .MESH_Y(4), .TEST_NUM(8), .INJECT_RATE(256),
    .LFSR_SEED(32'h1), .TIMEOUT_THRESHOLD(256)) u_a (
    .clk(clk), .rst(rst), .start_i(start_a), .node_id_i(node_a),
    .mcycle_i(mcycle), .new_test_vld_o(vld_a), .new_test_o(ent_a),
    .new_test_rdy_i(rdy_a), .issued_cnt_o(iss_a), .done_o(done_a));

  v_traffic_gen #(.MESH_X(4), .MESH_Y(4), .TEST_NUM(8), .INJECT_RATE(0),
    .LFSR_SEED(32'h1), .TIMEOUT_THRESHOLD(256)) u_z (
    .clk(clk), .rst(rst), .start_i(start_z), .node_id_i(node_o),
    .mcycle_i(mcycle), .new_test_vld_o(vld_z), .new_test_o(ent_z),
    .new_test_rdy_i(rdy_z), .issued_cnt_o(iss_z), .done_o(done_z));

  v_traffic_gen #(.MESH_X(4), .MESH_Y(4), .TEST_NUM(60000), .INJECT_RATE(64),
    .LFSR_SEED(32'h1), .TIMEOUT_THRESHOLD(256)) u_r (
    .clk(clk), .rst(rst), .start_i(start_r), .node_id_i(node_o),
    .mcycle_i(mcycle), .new_test_vld_o(vld_r), .new_test_o(ent_r),
    .new_test_rdy_i(rdy_r), .issued_cnt_o(iss_r), .done_o(done_r));

  v_traffic_gen #(.MESH_X(4), .MESH_Y(4), .TEST_NUM(0), .INJECT_RATE(256),
    .LFSR_SEED(32'h1), .TIMEOUT_THRESHOLD(256)) u_n (
    .clk(clk), .rst(rst), .start_i(start_n), .node_id_i(node_o),
    .mcycle_i(mcycle), .new_test_vld_o(vld_n), .new_test_o(ent_n),
    .new_test_rdy_i(rdy_n), .issued_cnt_o(iss_n), .done_o(done_n));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] lfsr_next(logic [31:0] s);
    return (s >> 1) ^ ({32{s[0]}} & 32'h80200003);
  endfunction

  function automatic logic [31:0] lfsr_at(int n);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < n; i++) s = lfsr_next(s);
    return s;
  endfunction

  function automatic io_port_t ref_route(node_id_t s, node_id_t t);
    if (t.x != s.x) return (t.x > s.x) ? PORT_E : PORT_W;
    if (t.y != s.y) return (t.y > s.y) ? PORT_N : PORT_S;
    return PORT_L;
  endfunction

  function automatic test_case_t exp_entry(node_id_t src, int k,
                                           logic [31:0] s, logic [63:0] mc);
    test_case_t e;
    node_id_t   t;
    e   = '0;
    t   = '0;
    t.x = {2'b00, s[9:8]};
    t.y = {2'b00, s[17:16]};
`ifndef TRAFFIC_GEN_SELF_TARGET_EN
    if (t.x == src.x && t.y == src.y) t.x = (src.x + 4'd1) & 4'd3;
`endif
    e.src_id                = src;
    e.tgt_id                = t;
    e.look_ahead_routing    = ref_route(src, t);
    e.txn_id                = 8'(k);
    e.qos_value             = s[31:28];
    e.flit_data             = {64'd0, 32'(k), s};
    e.timeout_threshold     = 16'd256;
    e.mcycle_when_generated = mc;
    return e;
  endfunction

  function automatic test_case_t no_mc(test_case_t e);
    test_case_t r;
    r = e;
    r.mcycle_when_generated = '0;
    return r;
  endfunction

  function automatic node_id_t nid(int x, int y);
    node_id_t n;
    n   = '0;
    n.x = 4'(x);
    n.y = 4'(y);
    return n;
  endfunction

  typedef struct {
    node_id_t src;
    node_id_t tgt;
    io_port_t exp;
  } vec_t;

  vec_t       vt[6];
  test_case_t stream1[8];
  test_case_t got[8];

  initial begin
    int n;
    int cnt;
    logic stalled;
    test_case_t hold;
    logic [31:0] s;

    vt[0] = '{nid(1,1), nid(2,1), PORT_E};
    vt[1] = '{nid(1,1), nid(0,1), PORT_W};
    vt[2] = '{nid(1,1), nid(1,2), PORT_N};
    vt[3] = '{nid(1,1), nid(1,0), PORT_S};
    vt[4] = '{nid(1,1), nid(1,1), PORT_L};
    vt[5] = '{nid(3,0), nid(0,3), PORT_W};

    node_a = nid(1, 1);
    node_o = nid(2, 3);
    rst = 1'b1;
    repeat (3) tick();

    chk("rst_vld", 256'(vld_a), 256'(0));
    chk("rst_entry", 256'(ent_a), 256'(0));
    chk("rst_issued", 256'(iss_a), 256'(0));
    chk("rst_done", 256'(done_a), 256'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      chk($sformatf("route%0d", i),
          256'(xy_first_hop(vt[i].src, vt[i].tgt)), 256'(vt[i].exp));

    // Back-to-back stream of 8 at full rate.
    s = 32'h1;
    rdy_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_vld_start", 256'(vld_a), 256'(0));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("a_vld%0d", k), 256'(vld_a), 256'(1));
      chk($sformatf("a_ent%0d", k), 256'(ent_a),
          256'(exp_entry(node_a, k, s, mcycle - 64'd1)));
      chk($sformatf("a_done%0d", k), 256'(done_a), 256'(0));
      stream1[k] = ent_a;
      s = lfsr_next(s);
    end
    tick();
    chk("a_done", 256'(done_a), 256'(1));
    chk("a_vld_end", 256'(vld_a), 256'(0));
    chk("a_issued", 256'(iss_a), 256'(8));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    chk("a_restart_vld", 256'(vld_a), 256'(0));
    chk("a_restart_done", 256'(done_a), 256'(1));
    chk("a_restart_iss", 256'(iss_a), 256'(8));

    // Stall for 10 cycles after three handshakes.
    do_reset();
    rdy_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    stalled = 1'b0;
    for (int c = 0; c < 80 && !done_a; c++) begin
      tick();
      if (n == 3 && !stalled) begin
        rdy_a = 1'b0;
        hold = ent_a;
        for (int j = 0; j < 10; j++) begin
          tick();
          chk($sformatf("stall_hold%0d", j), 256'(ent_a), 256'(hold));
          chk($sformatf("stall_vld%0d", j), 256'(vld_a), 256'(1));
          chk($sformatf("stall_iss%0d", j), 256'(iss_a), 256'(3));
        end
        rdy_a = 1'b1;
        stalled = 1'b1;
      end
      if (vld_a && rdy_a && n < 8) begin
        got[n] = ent_a;
        n++;
      end
    end
    chk("stall_count", 256'(n), 256'(8));
    chk("stall_done", 256'(done_a), 256'(1));
    for (int k = 0; k < 8; k++)
      chk($sformatf("stall_ent%0d", k), 256'(no_mc(got[k])),
          256'(no_mc(exp_entry(node_a, k,
                lfsr_at(k < 4 ? k : k + 10), 64'd0))));

    // Reset while an entry waits on ready.
    do_reset();
    rdy_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("rstmid_vld_pre", 256'(vld_a), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_vld", 256'(vld_a), 256'(0));
    chk("rstmid_iss", 256'(iss_a), 256'(0));
    chk("rstmid_ent", 256'(ent_a), 256'(0));
    cnt = 0;
    repeat (5) begin
      tick();
      if (vld_a) cnt++;
    end
    chk("rstmid_idle", 256'(cnt), 256'(0));
    rdy_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && !done_a; c++) begin
      tick();
      if (vld_a && rdy_a && n < 8) begin
        got[n] = ent_a;
        n++;
      end
    end
    chk("rerun_count", 256'(n), 256'(8));
    for (int k = 0; k < 8; k++)
      chk($sformatf("rerun_ent%0d", k), 256'(no_mc(got[k])),
          256'(no_mc(stream1[k])));

    // Seed 1 targets (0,0) first: a node at (0,0) sees a self-target.
    do_reset();
    node_a = nid(0, 0);
    rdy_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("self_ent", 256'(ent_a),
        256'(exp_entry(node_a, 0, 32'h1, mcycle - 64'd1)));
`ifdef TRAFFIC_GEN_SELF_TARGET_EN
    chk("self_route", 256'(ent_a.look_ahead_routing), 256'(PORT_L));
    chk("self_tgt_x", 256'(ent_a.tgt_id.x), 256'(0));
`else
    chk("self_route", 256'(ent_a.look_ahead_routing), 256'(PORT_E));
    chk("self_tgt_x", 256'(ent_a.tgt_id.x), 256'(1));
`endif
    repeat (12) tick();
    node_a = nid(1, 1);

    // Rate 0: nothing ever issues.
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    rdy_z = 1'b1;
    cnt = 0;
    repeat (1000) begin
      tick();
      if (vld_z) cnt++;
    end
    chk("zero_vld", 256'(cnt), 256'(0));
    chk("zero_done", 256'(done_z), 256'(0));
    chk("zero_iss", 256'(iss_z), 256'(0));

    // Rate 64/256 over 4096 cycles.
    rdy_r = 1'b1;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    cnt = 0;
    repeat (4096) begin
      tick();
      if (vld_r && rdy_r) cnt++;
    end
    rdy_r = 1'b0;
    tick();
    chk("rate_range", 256'(cnt >= 900 && cnt <= 1150), 256'(1));
    chk("rate_iss", 256'(iss_r), 256'(cnt));

    // Zero-length run goes straight to done.
    start_n = 1'b1;
    rdy_n = 1'b1;
    tick();
    start_n = 1'b0;
    chk("tn0_done", 256'(done_n), 256'(1));
    cnt = 0;
    repeat (20) begin
      tick();
      if (vld_n) cnt++;
    end
    chk("tn0_vld", 256'(cnt), 256'(0));
    chk("tn0_iss", 256'(iss_n), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
